// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - ALU_OP_* opcode encodings (4-bit alu_op field)
//   - alu_state_e: controller states (ST_DIV exists only when ALU_DIV_EN is defined)
//   - op_is_multicycle(): opcodes that leave IDLE for an iterative engine
// Configuration macro: ALU_DIV_EN (enables DIVU/REMU and the DIV state).
package alu_pkg;

  localparam logic [3:0] ALU_OP_AND   = 4'b0000;
  localparam logic [3:0] ALU_OP_OR    = 4'b0001;
  localparam logic [3:0] ALU_OP_ADD   = 4'b0010;
  localparam logic [3:0] ALU_OP_MUL   = 4'b0011;
  localparam logic [3:0] ALU_OP_MULHU = 4'b0100;
  localparam logic [3:0] ALU_OP_SUB   = 4'b0110;
  localparam logic [3:0] ALU_OP_LT    = 4'b0111;
  localparam logic [3:0] ALU_OP_SRL   = 4'b1000;
  localparam logic [3:0] ALU_OP_SLL   = 4'b1001;
  localparam logic [3:0] ALU_OP_SRA   = 4'b1010;
  localparam logic [3:0] ALU_OP_DIVU  = 4'b1011;
  localparam logic [3:0] ALU_OP_REMU  = 4'b1100;
  localparam logic [3:0] ALU_OP_XOR   = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
`ifdef ALU_DIV_EN
    ST_DIV  = 2'b10,
`endif
    ST_DONE = 2'b11
  } alu_state_e;

  // Opcodes that run on an iterative engine. Divide-by-zero is still
  // single-cycle; the caller masks that case using the operand value.
  function automatic logic op_is_multicycle(input logic [3:0] op);
    logic mc;
    case (op)
      ALU_OP_MUL, ALU_OP_MULHU: mc = 1'b1;
`ifdef ALU_DIV_EN
      ALU_OP_DIVU, ALU_OP_REMU: mc = 1'b1;
`endif
      default:                  mc = 1'b0;
    endcase
    return mc;
  endfunction

endpackage

// File: rtl/alu_seq_divu.sv
// alu_seq_divu: unsigned restoring divider core, one quotient bit per cycle.
// Only present when ALU_DIV_EN is defined.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             load operands and perform the first iteration this edge
//   dividend/divisor  operands (divisor must be non-zero; caller handles /0)
//   done              high in the cycle whose edge performs the last iteration
//   quotient          valid the cycle after done
//   remainder         valid the cycle after done
`ifdef ALU_DIV_EN
module alu_seq_divu #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  localparam int SH_W = $clog2(DATA_W);
  localparam logic [SH_W-1:0] CNT_LAST = SH_W'(DATA_W - 1);
  localparam logic [SH_W-1:0] CNT_ONE  = SH_W'(1);

  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [SH_W-1:0]     cnt_q, cnt_d;
  logic                run_q, run_d;
  logic [2*DATA_W-1:0] step_first;
  logic [2*DATA_W-1:0] step_run;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. Returns {rem, quo}.
  function automatic logic [2*DATA_W-1:0] div_step(input logic [DATA_W-1:0] rem,
                                                    input logic [DATA_W-1:0] quo,
                                                    input logic [DATA_W-1:0] dvs);
    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] rem_n;
    logic [DATA_W-1:0] quo_n;
    trial = {rem, quo[DATA_W-1]} - {1'b0, dvs};
    if (trial[DATA_W]) begin
      rem_n = {rem[DATA_W-2:0], quo[DATA_W-1]};
      quo_n = {quo[DATA_W-2:0], 1'b0};
    end else begin
      rem_n = trial[DATA_W-1:0];
      quo_n = {quo[DATA_W-2:0], 1'b1};
    end
    return {rem_n, quo_n};
  endfunction

  assign done      = run_q && (cnt_q == CNT_LAST);
  assign quotient  = quo_q;
  assign remainder = rem_q;

  // Next-state: load and first iteration on start, then DATA_W-1 more iterations.
  always_comb begin
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    run_d      = run_q;
    step_first = div_step({DATA_W{1'b0}}, dividend, divisor);
    step_run   = div_step(rem_q, quo_q, dvs_q);
    if (start) begin
      rem_d = step_first[2*DATA_W-1:DATA_W];
      quo_d = step_first[DATA_W-1:0];
      dvs_d = divisor;
      cnt_d = CNT_ONE;
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = step_run[2*DATA_W-1:DATA_W];
      quo_d = step_run[DATA_W-1:0];
      if (cnt_q == CNT_LAST) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= {DATA_W{1'b0}};
      quo_q <= {DATA_W{1'b0}};
      dvs_q <= {DATA_W{1'b0}};
      cnt_q <= {SH_W{1'b0}};
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle ALU. Base ops complete in one registered
// cycle; MUL/MULHU use an inline shift-add multiplier; DIVU/REMU use the
// alu_seq_divu core when ALU_DIV_EN is defined (otherwise they are illegal).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operation handshake (op1, op2, alu_op)
//   out_valid / out_ready result handshake (result, zero, illegal)
//   busy                  controller is not in IDLE
// Configuration macro: ALU_DIV_EN.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [3:0]        alu_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              illegal,
  output logic              busy
);
  localparam int SH_W = $clog2(DATA_W);
  localparam logic [SH_W-1:0] CNT_LAST = SH_W'(DATA_W - 1);
  localparam logic [SH_W-1:0] CNT_ONE  = SH_W'(1);

  alu_state_e          state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;
  logic                illegal_q, illegal_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic                hi_q, hi_d;       // MULHU (vs MUL) or REMU (vs DIVU)
  logic [SH_W-1:0]     cnt_q, cnt_d;

  logic                accept;
  logic                start_mc;
  logic [DATA_W-1:0]   base_res;
  logic                base_ill;
  logic [DATA_W-1:0]   done_res;
  logic [SH_W-1:0]     shamt;

`ifdef ALU_DIV_EN
  logic                div_op;
  logic                div_start;
  logic                div_done;
  logic [DATA_W-1:0]   div_quo;
  logic [DATA_W-1:0]   div_rem;
  logic                div_sel_q, div_sel_d;

  assign div_op   = (alu_op == ALU_OP_DIVU) || (alu_op == ALU_OP_REMU);
  // Division by zero is answered immediately from the base datapath.
  assign start_mc = op_is_multicycle(alu_op) && !(div_op && (op2 == {DATA_W{1'b0}}));

  alu_seq_divu #(.DATA_W(DATA_W)) u_divu (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (op1),
    .divisor   (op2),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`else
  assign start_mc = op_is_multicycle(alu_op);
`endif

  // A new op may enter only from IDLE and only if the output slot is free
  // or being emptied this cycle.
  assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign shamt     = op2[SH_W-1:0];

  // One shift-add step on {hi, lo}: add multiplicand to hi when lo[0] is set,
  // then shift the whole product right, keeping the carry.
  function automatic logic [2*DATA_W-1:0] mul_step(input logic [2*DATA_W-1:0] p,
                                                    input logic [DATA_W-1:0]   m);
    logic [DATA_W:0] upper;
    if (p[0]) begin
      upper = {1'b0, p[2*DATA_W-1:DATA_W]} + {1'b0, m};
    end else begin
      upper = {1'b0, p[2*DATA_W-1:DATA_W]};
    end
    return {upper, p[DATA_W-1:1]};
  endfunction

  // Single-cycle datapath and opcode legality.
  always_comb begin
    base_res = {DATA_W{1'b0}};
    base_ill = 1'b0;
    case (alu_op)
      ALU_OP_AND:   base_res = op1 & op2;
      ALU_OP_OR:    base_res = op1 | op2;
      ALU_OP_XOR:   base_res = op1 ^ op2;
      ALU_OP_ADD:   base_res = op1 + op2;
      ALU_OP_SUB:   base_res = op1 - op2;
      ALU_OP_LT:    base_res = {{(DATA_W-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_OP_SRL:   base_res = op1 >> shamt;
      ALU_OP_SLL:   base_res = op1 << shamt;
      ALU_OP_SRA:   base_res = $unsigned($signed(op1) >>> shamt);
      ALU_OP_MUL,
      ALU_OP_MULHU: base_res = {DATA_W{1'b0}};  // produced by the MUL state
`ifdef ALU_DIV_EN
      ALU_OP_DIVU:  base_res = {DATA_W{1'b1}};  // only reaches the output for op2 == 0
      ALU_OP_REMU:  base_res = op1;             // only reaches the output for op2 == 0
`endif
      default:      base_ill = 1'b1;
    endcase
  end

  // Select the finished multi-cycle result.
  always_comb begin
    done_res = hi_q ? prod_q[2*DATA_W-1:DATA_W] : prod_q[DATA_W-1:0];
`ifdef ALU_DIV_EN
    if (div_sel_q) begin
      done_res = hi_q ? div_rem : div_quo;
    end else begin
      done_res = hi_q ? prod_q[2*DATA_W-1:DATA_W] : prod_q[DATA_W-1:0];
    end
`endif
  end

  // Controller next-state and output-register loading.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    hi_d        = hi_q;
    cnt_d       = cnt_q;
`ifdef ALU_DIV_EN
    div_start   = 1'b0;
    div_sel_d   = div_sel_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept && start_mc) begin
`ifdef ALU_DIV_EN
          if (div_op) begin
            div_start = 1'b1;
            div_sel_d = 1'b1;
            hi_d      = (alu_op == ALU_OP_REMU);
            state_d   = ST_DIV;
          end else begin
            div_sel_d = 1'b0;
            hi_d      = (alu_op == ALU_OP_MULHU);
            prod_d    = mul_step({{DATA_W{1'b0}}, op2}, op1);
            mcand_d   = op1;
            cnt_d     = CNT_ONE;
            state_d   = ST_MUL;
          end
`else
          hi_d    = (alu_op == ALU_OP_MULHU);
          prod_d  = mul_step({{DATA_W{1'b0}}, op2}, op1);
          mcand_d = op1;
          cnt_d   = CNT_ONE;
          state_d = ST_MUL;
`endif
        end else if (accept) begin
          result_d    = base_res;
          zero_d      = (base_res == {DATA_W{1'b0}});
          illegal_d   = base_ill;
          out_valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        prod_d = mul_step(prod_q, mcand_q);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef ALU_DIV_EN
      ST_DIV: begin
        if (div_done) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DIV;
        end
      end
`endif
      ST_DONE: begin
        result_d    = done_res;
        zero_d      = (done_res == {DATA_W{1'b0}});
        illegal_d   = 1'b0;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller, output and multiplier registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= {DATA_W{1'b0}};
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      prod_q      <= {(2*DATA_W){1'b0}};
      mcand_q     <= {DATA_W{1'b0}};
      hi_q        <= 1'b0;
      cnt_q       <= {SH_W{1'b0}};
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      hi_q        <= hi_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef ALU_DIV_EN
  // Remembers whether the pending multi-cycle result comes from the divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_sel_q <= 1'b0;
    end else begin
      div_sel_q <= div_sel_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq with a queue-based scoreboard.
// Stimulus pushes the expected response when an op is accepted; a monitor
// on the falling edge pops and compares whenever a result is taken.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         ill;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic [3:0]   alu_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;
  logic         busy;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  int   n_pushed = 0;
  int   cyc      = 0;

  alu_seq #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // Scoreboard monitor: a result is consumed when out_valid && out_ready at the edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got result 0x%08h, expected no output", result);
      end else begin
        e = sb.pop_front();
        n_out++;
        chk("sb_result", result, e.res);
        chk1("sb_zero", zero, e.zero);
        chk1("sb_illegal", illegal, e.ill);
      end
    end
  end

  // Present one op and hold it until accepted; pushes the expected response.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic eill);
    int w;
    alu_op   = op;
    op1      = a;
    op2      = b;
    in_valid = 1'b1;
    w        = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk1("accept_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
    end else begin
      sb.push_back('{res: er, zero: (er == {W{1'b0}}), ill: eill});
      n_pushed++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Issue with out_ready=1, measure accept-to-out_valid latency, let result drain.
  task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic eill,
                        input int exp_lat);
    int lat;
    logic busy_ok;
    issue(op, a, b, er, eill);
    lat     = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (!busy || in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, W'(lat), W'(exp_lat));
    if (exp_lat > 1) chk1({name, "_busy"}, busy_ok, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   t0;
    logic ok;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op1       = {W{1'b0}};
    op2       = {W{1'b0}};
    alu_op    = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk1("rst_zero", zero, 1'b0);
    chk1("rst_illegal", illegal, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("idle_in_ready", in_ready, 1'b1);

    // Base ops
    run_op("add",      ALU_OP_ADD,  32'd5,        32'd7,        32'd12,       1'b0, 1);
    run_op("sub_zero", ALU_OP_SUB,  32'd7,        32'd7,        32'd0,        1'b0, 1);
    run_op("add_wrap", ALU_OP_ADD,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1);
    run_op("sra",      ALU_OP_SRA,  32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1);
    run_op("srl",      ALU_OP_SRL,  32'h80000000, 32'd4,        32'h08000000, 1'b0, 1);
    run_op("sll_mask", ALU_OP_SLL,  32'd1,        32'h00000021, 32'd2,        1'b0, 1);
    run_op("sll31",    ALU_OP_SLL,  32'd1,        32'd31,       32'h80000000, 1'b0, 1);
    run_op("lt_true",  ALU_OP_LT,   32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1);
    run_op("lt_false", ALU_OP_LT,   32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1);
    run_op("and",      ALU_OP_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1);
    run_op("or",       ALU_OP_OR,   32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1);
    run_op("xor",      ALU_OP_XOR,  32'h000000FF, 32'h0000000F, 32'h000000F0, 1'b0, 1);
    run_op("ill_f",    4'b1111,     32'd3,        32'd4,        32'd0,        1'b1, 1);
    run_op("ill_5",    4'b0101,     32'd3,        32'd4,        32'd0,        1'b1, 1);

    // Multiply
    run_op("mul",      ALU_OP_MUL,   32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, W + 1);
    run_op("mulhu",    ALU_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, W + 1);
    run_op("mul_lo",   ALU_OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, W + 1);
    run_op("mulhu_1",  ALU_OP_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, 1'b0, W + 1);

    // Backpressure: hold, then release with a new op pending
    out_ready = 1'b0;
    issue(ALU_OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0);
    alu_op   = ALU_OP_ADD;
    op1      = 32'd3;
    op2      = 32'd4;
    in_valid = 1'b1;
    ok       = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (in_ready || !out_valid || result !== 32'd2) ok = 1'b0;
    end
    chk1("stall_hold", ok, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(ALU_OP_ADD, 32'd3, 32'd4, 32'd7, 1'b0);
    chk1("release_out_valid", out_valid, 1'b1);
    chk("release_result", result, 32'd7);
    t0 = cyc;
    issue(ALU_OP_XOR, 32'h0F, 32'hFF, 32'hF0, 1'b0);
    issue(ALU_OP_OR,  32'h10, 32'h01, 32'h11, 1'b0);
    issue(ALU_OP_SUB, 32'd10, 32'd3,  32'd7,  1'b0);
    chk("b2b_cycles", W'(cyc - t0), 32'd3);
    repeat (2) @(posedge clk);
    #1;

    // Divide
`ifdef ALU_DIV_EN
    run_op("divu",      ALU_OP_DIVU, 32'd100,      32'd7,  32'd14,       1'b0, W + 1);
    run_op("remu",      ALU_OP_REMU, 32'd100,      32'd7,  32'd2,        1'b0, W + 1);
    run_op("divu_big",  ALU_OP_DIVU, 32'hFFFFFFFF, 32'd1,  32'hFFFFFFFF, 1'b0, W + 1);
    run_op("remu_16",   ALU_OP_REMU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 1'b0, W + 1);
    run_op("divu_zero", ALU_OP_DIVU, 32'd5,        32'd0,  32'hFFFFFFFF, 1'b0, 1);
    run_op("remu_zero", ALU_OP_REMU, 32'd9,        32'd0,  32'd9,        1'b0, 1);
`else
    run_op("divu_ill",  ALU_OP_DIVU, 32'd100,      32'd7,  32'd0,        1'b1, 1);
    run_op("remu_ill",  ALU_OP_REMU, 32'd100,      32'd7,  32'd0,        1'b1, 1);
`endif
    run_op("pre_rst", ALU_OP_ADD, 32'd40, 32'd2, 32'd42, 1'b0, 1);

    // Reset in the middle of a multiply
    issue(ALU_OP_MUL, 32'd3, 32'd5, 32'd15, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_result", result, 32'h0);
    chk1("midrst_zero", zero, 1'b0);
    chk1("midrst_illegal", illegal, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    n_pushed -= sb.size();
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op("post_rst_add", ALU_OP_ADD, 32'd20, 32'd22, 32'd42, 1'b0, 1);
    ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) ok = 1'b0;
    end
    chk1("no_stale_output", ok, 1'b1);

    chk("all_results_seen", W'(n_out), W'(n_pushed));
    chk("scoreboard_empty", W'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
